// File: rtl/data_mem_dma.sv
// Word-copy DMA engine driving the data memory port; copies len words src -> dst in ascending order.
// Optional running checksum of words read is enabled by defining DMA_CHECKSUM_EN.
module data_mem_dma #(
    parameter logic [31:0] DATA_START = 32'h10000000,
    parameter int unsigned DATA_WORDS = 'h40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    // Segment bounds held in 34 bits so base + 4*len cannot wrap past the check.
    localparam logic [33:0] SegBase = {2'b00, DATA_START};
    localparam logic [33:0] SegEnd  = SegBase + (34'(DATA_WORDS) << 2);

    state_e      state_q, state_d;
    logic [31:0] cur_src_q, cur_src_d;
    logic [31:0] cur_dst_q, cur_dst_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] buf_q, buf_d;
    logic        error_q, error_d;

    logic [33:0] len_bytes;
    logic [33:0] src_end;
    logic [33:0] dst_end;
    logic        req_ok;

    always_comb begin
        len_bytes = {16'h0000, len, 2'b00};
        src_end   = {2'b00, src_addr} + len_bytes;
        dst_end   = {2'b00, dst_addr} + len_bytes;
        req_ok    = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00)
                 && ({2'b00, src_addr} >= SegBase) && (src_end <= SegEnd)
                 && ({2'b00, dst_addr} >= SegBase) && (dst_end <= SegEnd);
    end

`ifdef DMA_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        error_d     = error_q;
`ifdef DMA_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_src_d   = src_addr;
                    cur_dst_d   = dst_addr;
                    remaining_d = len;
                    error_d     = !req_ok;
`ifdef DMA_CHECKSUM_EN
                    sum_d       = '0;
`endif
                    state_d     = (!req_ok || len == 16'd0) ? StDone : StRd;
                end
            end
            StRd: begin
                buf_d   = mem_rdata;
`ifdef DMA_CHECKSUM_EN
                sum_d   = sum_q + mem_rdata;
`endif
                state_d = StWr;
            end
            StWr: begin
                cur_src_d   = cur_src_q + 32'd4;
                cur_dst_d   = cur_dst_q + 32'd4;
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? StDone : StRd;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            buf_q       <= buf_d;
            error_q     <= error_d;
        end
    end

`ifdef DMA_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    // Memory strobes depend on registered state only, never on start.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StRd: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = cur_src_q;
            end
            StWr: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = cur_dst_q;
                mem_wdata = buf_q;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign error = error_q;

endmodule

// File: tb/tb_data_mem_dma.sv
// Scoreboard bench for data_mem_dma: expected writes queued at stimulus time, compared to observed writes.
module tb_data_mem_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, error;
    logic [31:0] checksum, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    always #5 clk = ~clk;

`ifdef DMA_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    data_mem_dma dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    // 256-word memory window at 0x10000000; preload goes through the same process as DMA writes.
    logic [31:0] mem [0:255];
    logic        in_rng;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    assign in_rng    = (mem_addr[31:10] == 22'h040000);
    assign mem_rdata = (mem_read && in_rng) ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_write && in_rng) mem[mem_addr[9:2]] <= mem_wdata;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          obs_done, busy_n, strobe_n;
    logic [31:0] obs_sum;
    logic        obs_err;

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Drives one request and records what the DUT does until done (or the cycle budget runs out).
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int inj_at, input logic [31:0] is, input logic [31:0] id,
                            input logic [15:0] il);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk);
        #1 start = 1'b0;
        obs_done = -1; busy_n = 0; strobe_n = 0; obs_sum = '0; obs_err = 1'bx;
        obs_q.delete();
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_at) begin
                start = 1'b1; src_addr = is; dst_addr = id; len = il;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) busy_n++;
            if (mem_read || mem_write) strobe_n++;
            if (mem_write) obs_q.push_back({mem_addr, mem_wdata});
            if (done) begin
                obs_done = k; obs_sum = checksum; obs_err = error;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, error, mem_read, mem_write} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, done, error, mem_read, mem_write});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if (checksum !== 32'h0) $display("FAIL reset_checksum: got %h want 0", checksum);
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic check_writes(input string name);
        logic [63:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0) begin
                $display("FAIL %s_write: got none want %h", name, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL %s_write: got %h want %h", name, o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL %s_extra_writes: got %0d want 0", name, obs_q.size());
        else pass_cnt++;
    endtask

    task automatic test_basic_copy();
        for (int i = 0; i < 4; i++) begin
            preload(8'(i), 32'(i + 1));
            preload(8'(64 + i), 32'h0);
            exp_q.push_back({32'h10000100 + 32'(4 * i), 32'(i + 1)});
        end
        run_xfer(32'h10000000, 32'h10000100, 16'd4, -1, '0, '0, '0);
        total_cnt++;
        if (obs_done !== 9) $display("FAIL copy_done_cycle: got %0d want 9", obs_done);
        else pass_cnt++;
        total_cnt++;
        if (busy_n !== 8) $display("FAIL copy_busy_cycles: got %0d want 8", busy_n);
        else pass_cnt++;
        total_cnt++;
        if (obs_sum !== (CkEn ? 32'd10 : 32'd0))
            $display("FAIL copy_checksum: got %0d want %0d", obs_sum, CkEn ? 10 : 0);
        else pass_cnt++;
        total_cnt++;
        if (obs_err !== 1'b0) $display("FAIL copy_error: got %b want 0", obs_err);
        else pass_cnt++;
        check_writes("copy");
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (mem[64 + i] !== 32'(i + 1))
                $display("FAIL copy_readback: got %h want %h", mem[64 + i], i + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero_len();
        run_xfer(32'h10000000, 32'h10000100, 16'd0, -1, '0, '0, '0);
        total_cnt++;
        if (obs_done !== 1) $display("FAIL zero_done_cycle: got %0d want 1", obs_done);
        else pass_cnt++;
        total_cnt++;
        if (busy_n + strobe_n !== 0)
            $display("FAIL zero_activity: got busy=%0d strobes=%0d want 0", busy_n, strobe_n);
        else pass_cnt++;
        total_cnt++;
        if (obs_err !== 1'b0) $display("FAIL zero_error: got %b want 0", obs_err);
        else pass_cnt++;
    endtask

    task automatic test_invalid();
        logic [31:0] srcs [3];
        logic [31:0] dsts [3];
        logic [15:0] lens [3];
        srcs[0] = 32'h10000002; dsts[0] = 32'h10000100; lens[0] = 16'd1;
        srcs[1] = 32'h10000000; dsts[1] = 32'h0FFFFFFC; lens[1] = 16'd1;
        srcs[2] = 32'h100FFFFC; dsts[2] = 32'h10000100; lens[2] = 16'd2;
        for (int i = 0; i < 3; i++) begin
            run_xfer(srcs[i], dsts[i], lens[i], -1, '0, '0, '0);
            total_cnt++;
            if (obs_done !== 1) $display("FAIL invalid%0d_done_cycle: got %0d want 1", i, obs_done);
            else pass_cnt++;
            total_cnt++;
            if (obs_err !== 1'b1) $display("FAIL invalid%0d_error: got %b want 1", i, obs_err);
            else pass_cnt++;
            total_cnt++;
            if (busy_n + strobe_n !== 0)
                $display("FAIL invalid%0d_activity: got busy=%0d strobes=%0d want 0", i, busy_n,
                         strobe_n);
            else pass_cnt++;
            repeat (2) @(negedge clk);
            total_cnt++;
            if (error !== 1'b1) $display("FAIL invalid%0d_error_held: got %b want 1", i, error);
            else pass_cnt++;
        end
    endtask

    task automatic test_overlap();
        preload(8'd0, 32'h11111111);
        preload(8'd1, 32'h22222222);
        preload(8'd2, 32'h33333333);
        exp_q.push_back({32'h10000004, 32'h11111111});
        exp_q.push_back({32'h10000008, 32'h11111111});
        run_xfer(32'h10000000, 32'h10000004, 16'd2, -1, '0, '0, '0);
        total_cnt++;
        if (obs_done !== 5) $display("FAIL overlap_done_cycle: got %0d want 5", obs_done);
        else pass_cnt++;
        total_cnt++;
        if (obs_err !== 1'b0) $display("FAIL overlap_error_cleared: got %b want 0", obs_err);
        else pass_cnt++;
        total_cnt++;
        if (obs_sum !== (CkEn ? 32'h22222222 : 32'h0))
            $display("FAIL overlap_checksum: got %h want %h", obs_sum,
                     CkEn ? 32'h22222222 : 32'h0);
        else pass_cnt++;
        check_writes("overlap");
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (mem[i] !== 32'h11111111)
                $display("FAIL overlap_mem%0d: got %h want 11111111", i, mem[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_start();
        int late_busy;
        preload(8'd32, 32'hA1);
        preload(8'd33, 32'hB2);
        preload(8'd34, 32'hC3);
        preload(8'd192, 32'h5A5A5A5A);
        exp_q.push_back({32'h10000200, 32'hA1});
        exp_q.push_back({32'h10000204, 32'hB2});
        exp_q.push_back({32'h10000208, 32'hC3});
        run_xfer(32'h10000080, 32'h10000200, 16'd3, 2, 32'h10000000, 32'h10000300, 16'd1);
        total_cnt++;
        if (obs_done !== 7) $display("FAIL busy_start_done_cycle: got %0d want 7", obs_done);
        else pass_cnt++;
        total_cnt++;
        if (obs_sum !== (CkEn ? 32'd534 : 32'd0))
            $display("FAIL busy_start_checksum: got %0d want %0d", obs_sum, CkEn ? 534 : 0);
        else pass_cnt++;
        check_writes("busy_start");
        late_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) late_busy++;
        end
        total_cnt++;
        if (late_busy !== 0) $display("FAIL busy_start_queued: got %0d active cycles want 0", late_busy);
        else pass_cnt++;
        total_cnt++;
        if (mem[192] !== 32'h5A5A5A5A)
            $display("FAIL busy_start_stray: got %h want 5a5a5a5a", mem[192]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int after_act;
        for (int i = 0; i < 4; i++) begin
            preload(8'(16 + i), 32'h11 * 32'(i + 1));
            preload(8'(96 + i), 32'hCAFE0000 + 32'(i));
        end
        @(negedge clk);
        start = 1'b1; src_addr = 32'h10000040; dst_addr = 32'h10000180; len = 16'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({mem_write, mem_addr} !== {1'b1, 32'h10000184})
            $display("FAIL rst_mid_pre: got we=%b addr=%h want we=1 addr=10000184", mem_write,
                     mem_addr);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({mem_write, mem_read, busy} !== 3'b000)
            $display("FAIL rst_mid_drop: got %b want 000", {mem_write, mem_read, busy});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (mem[96] !== 32'h11) $display("FAIL rst_mid_word1: got %h want 11", mem[96]);
        else pass_cnt++;
        for (int i = 1; i < 4; i++) begin
            total_cnt++;
            if (mem[96 + i] !== 32'hCAFE0000 + 32'(i))
                $display("FAIL rst_mid_untouched%0d: got %h want %h", i, mem[96 + i],
                         32'hCAFE0000 + 32'(i));
            else pass_cnt++;
        end
        reset = 1'b1;
        after_act = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done || mem_read || mem_write) after_act++;
        end
        total_cnt++;
        if (after_act !== 0) $display("FAIL rst_mid_resumed: got %0d active cycles want 0", after_act);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_invalid();
        test_overlap();
        test_busy_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_dma.md
# data_mem_dma

Word-copy DMA engine that acts as the initiator on the data memory port. Given a source address, destination address and word count, it drives the memory's `addr`/`data_in`/`mem_read`/`mem_write` signals to copy the block one word at a time. It signals completion with a `done` pulse. It sits beside the datapath and shares the data memory through an external mux that selects the DMA while `busy` is high.

## Interface
Parameters:
- `DATA_START`, default 32'h10000000: byte base of the valid data segment.
- `DATA_WORDS`, default 'h40000: segment size in 32-bit words; the valid byte range is [DATA_START, DATA_START+4*DATA_WORDS).

Ports (the one clock is `clk`; reset is `reset`, which is asynchronous and active-low):
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `start` in 1: request; sampled only in IDLE.
- `src_addr` in 32: source byte address; must be word-aligned.
- `dst_addr` in 32: destination byte address; must be word-aligned.
- `len` in 16: number of words to copy.
- `busy` out 1: high in RD and WR states.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: request rejected; held until the next accepted `start`.
- `checksum` out 32: running sum of the words read (see Configuration).
- `mem_addr` out 32: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr` while `mem_read` is high.
- `mem_read` out 1: read enable.
- `mem_write` out 1: write enable; the memory commits on posedge.

## Operation
- The FSM has four states: IDLE, RD, WR and DONE.
- IDLE:
  - On `start`=1, latch `src_addr`, `dst_addr` and `len`, and clear `error` and `checksum`.
  - Validate the request:
    - Both addresses must have addr[1:0]==0.
    - base+4*len must be ≤ DATA_START+4*DATA_WORDS, and base must be ≥ DATA_START, for both bases. Compute this in 34-bit arithmetic so wrap-around is caught.
  - If the request is invalid, set `error`=1 and go to DONE. No memory access occurs.
  - If `len`==0, go to DONE with `error`=0.
  - Otherwise go to RD.
- RD:
  - Drive `mem_read`=1 and `mem_addr`=cur_src.
  - At posedge, capture `mem_rdata` into the word buffer and go to WR.
- WR:
  - Drive `mem_write`=1, `mem_addr`=cur_dst and `mem_wdata`=buffer.
  - At posedge, cur_src+=4, cur_dst+=4 and remaining-=1.
  - If remaining (before the decrement) was 1, go to DONE; otherwise go to RD.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored, and it is not queued.
- Copy order is strictly ascending.
  - With an overlapping range where dst>src, words that have already been written are re-read. This propagating-fill result is the defined behaviour.
- Outside RD and WR: `mem_read`=`mem_write`=0, and `mem_addr`=`mem_wdata`=0.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `mem_read` and `mem_write` are 0; `mem_addr`, `mem_wdata` and `checksum` are 0.
- Reset is asynchronous. Asserting it mid-transfer drops `mem_write` and `mem_read` immediately. Writes committed at earlier edges remain in memory, and the transfer does not resume after reset releases.
- Latency, with the accept edge counted as edge 0:
  - First RD is cycle 1.
  - A copy of `len`=N≥1 words occupies 2N cycles of `busy`.
  - `done` is high in cycle 2N+1.
  - For `len`=0 or a rejected request, `done` is high in cycle 1 and `busy` never rises.
- `mem_*` outputs are Moore outputs from registered state only, with no combinational path from `start`.
- The earliest a new `start` can be accepted is the cycle after `done`.

## Configuration
- `DMA_CHECKSUM_EN` defined:
  - At each RD posedge, `checksum` <= `checksum` + `mem_rdata` (mod 2^32).
  - The value is cleared on an accepted `start` and holds after `done` until the next accept.
- `DMA_CHECKSUM_EN` undefined: `checksum` is constant 0 and no adder is instantiated.

## Test plan
- Preload words 1,2,3,4 at 0x10000000, then start src=0x10000000, dst=0x10000100, len=4. Required: 0x10000100..0x1000010C read back 1,2,3,4; `done` in cycle 9; `checksum`=10 when the macro is defined, 0 otherwise.
- len=0 → `done` in cycle 1; `busy`, `mem_read` and `mem_write` never assert; `error`=0.
- Invalid requests, each giving `error`=1 and `done` in cycle 1 with zero memory strobes:
  - src=0x10000002 (misaligned).
  - dst=0x0FFFFFFC (below the segment).
  - src=0x100FFFFC with len=2 (past the segment end).
- Overlapping copy: src=0x10000000 holding A,B,C, dst=0x10000004, len=2 → memory becomes A,A,A.
- Assert `reset`=0 during the WR cycle of word 2 of a len=4 copy. Required: `mem_write` drops within the same cycle; word 1 is written; words 2..4 at the destination are untouched; after release the state is IDLE and `done` is never pulsed.
- Pulse `start` while `busy`=1 with different addresses → ignored; the original copy completes unchanged.
